// File: rtl/frac_tick_scheduler_pkg.sv
// Shared types and elaboration-time rate math for the fractional tick scheduler.
// step_from_rate rounds 2^w * f_tick / f_clk to the nearest integer.
package frac_sched_pkg;
  import real_math_pkg::*;

  typedef enum logic {IDLE, RUN} sched_state_t;

  function automatic real pow2(input int w);
    real s;
    s = 1.0;
    for (int i = 0; i < w; i++) s = s * 2.0;
    return s;
  endfunction

  function automatic logic [63:0] step_from_rate(input real f_tick, input real f_clk, input int w);
    logic [63:0] r;
    r = longint'(trunc(pow2(w) * f_tick / f_clk + 0.5));
    return r;
  endfunction

  // Signed error of the rounded step versus the ideal rate, in parts per million.
  function automatic real rate_error_ppm(input real f_tick, input real f_clk, input int w);
    real x, res, delta;
    x     = pow2(w) * f_tick / f_clk;
    res   = fmod(x, 1.0);
    delta = (res >= 0.5) ? (1.0 - res) : -res;
    return (abs(x) > 0.0) ? delta / x * 1.0e6 : 0.0;
  endfunction

endpackage

// File: rtl/real_math_pkg.sv
// Real-number helpers usable from constant functions at elaboration time.
// Truncation goes through a 64-bit integer, so magnitudes must stay below 2^63.
package real_math_pkg;

  function automatic real trunc(input real x);
    longint t;
    t = longint'(x);
    if (x >= 0.0 && real'(t) > x) t = t - 1;
    else if (x < 0.0 && real'(t) < x) t = t + 1;
    return real'(t);
  endfunction

  function automatic real fmod(input real a, input real b);
    return a - b * trunc(a / b);
  endfunction

  function automatic real abs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

endpackage

// File: rtl/frac_tick_scheduler_if.sv
// Step reload channel: valid/ready transfer of a new phase increment.
// Producer holds cfg_step stable while cfg_valid is high and cfg_ready is low.
interface frac_tick_scheduler_if #(parameter int ACC_W = 32);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_step;

  modport master (output cfg_valid, output cfg_step, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_step, output cfg_ready);
endinterface

// File: rtl/frac_tick_scheduler_acc.sv
// Phase accumulator: acc advances by step when add is set; carry is the combinational overflow.
// clr zeroes acc and suppresses carry on the same edge.
module frac_phase_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] step,
  output logic [W-1:0] acc,
  output logic         carry
);

  logic [W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, step};
  assign carry = add & ~clr & sum[W];

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (add)   acc <= sum[W-1:0];
  end

endmodule

// File: rtl/frac_tick_scheduler.sv
// Fractional-rate strobe: tick registered one cycle after the carrying edge, avg rate step/2^ACC_W.
// Step reloads via valid/ready; ready drops while a reload waits for the next tick boundary.
module frac_tick_scheduler
  import frac_sched_pkg::*;
#(
  parameter real              CLK_HZ   = 100.0e6,
  parameter real              TICK_HZ  = 1.0e6,
  parameter int               ACC_W    = 32,
  parameter int               CNT_W    = 16,
  parameter logic [ACC_W-1:0] DEF_STEP = ACC_W'(step_from_rate(TICK_HZ, CLK_HZ, ACC_W))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  frac_tick_scheduler_if.slave  cfg,
  output logic                  tick,
  output logic [CNT_W-1:0]      tick_cnt,
  output logic                  running,
  output logic                  pending
);

  if (!(TICK_HZ > 0.0) || TICK_HZ > CLK_HZ / 2.0) begin : g_bad_rate
    $error("frac_tick_scheduler: TICK_HZ must be in (0, CLK_HZ/2]");
  end
  if (ACC_W < 4) begin : g_bad_width
    $error("frac_tick_scheduler: ACC_W must be at least 4");
  end

  sched_state_t     state;
  logic [ACC_W-1:0] step;
  logic [ACC_W-1:0] pend_step;
  logic [ACC_W-1:0] acc;
  logic             add;
  logic             leaving;
  logic             carry;
  logic             xfer;

  assign add           = (state == RUN) && en;
  assign leaving       = (state == RUN) && !en;
  assign xfer          = cfg.cfg_valid && !pending;
  assign cfg.cfg_ready = !pending;

  frac_phase_acc #(.W(ACC_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .add   (add),
    .step  (step),
    .acc   (acc),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= DEF_STEP;
      pend_step <= '0;
      pending   <= 1'b0;
      tick      <= 1'b0;
      tick_cnt  <= '0;
      running   <= 1'b0;
    end else begin
      tick <= carry;
      if (clr)        tick_cnt <= '0;
      else if (carry) tick_cnt <= tick_cnt + CNT_W'(1);

      case (state)
        IDLE: if (en) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (!en) begin
          state   <= IDLE;
          running <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      // A parked step lands on a carry (old step used for that addition) or on IDLE entry.
      if (pending && (carry || leaving)) begin
        step    <= pend_step;
        pending <= 1'b0;
      end else if (xfer) begin
        if (state == IDLE || leaving) begin
          step <= cfg.cfg_step;
        end else begin
          pend_step <= cfg.cfg_step;
          pending   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_tick_scheduler.sv
// Directed bench: an 8-bit accumulator instance for timing/handshake cases and a default instance for rate.
module tb_frac_tick_scheduler;
  import frac_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst8 = 1'b1, en8 = 1'b1, clr8 = 1'b0;
  logic        tick8, run8, pend8;
  logic [15:0] cnt8;
  logic        rst32 = 1'b1, en32 = 1'b0, clr32 = 1'b0;
  logic        tick32, run32, pend32;
  logic [31:0] cnt32;

  int n_checks = 0;
  int n_errors = 0;

  frac_tick_scheduler_if #(.ACC_W(8))  cfg8 ();
  frac_tick_scheduler_if #(.ACC_W(32)) cfg32 ();

  frac_tick_scheduler #(.ACC_W(8), .CNT_W(16), .DEF_STEP(8'd64)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .clr(clr8), .cfg(cfg8.slave),
    .tick(tick8), .tick_cnt(cnt8), .running(run8), .pending(pend8)
  );

  frac_tick_scheduler #(.CNT_W(32)) dut32 (
    .clk(clk), .rst(rst32), .en(en32), .clr(clr32), .cfg(cfg32.slave),
    .tick(tick32), .tick_cnt(cnt32), .running(run32), .pending(pend32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Park in IDLE, load a step directly, clear phase/count, then enter RUN (acc = 0).
  task automatic restart8(input logic [7:0] s);
    en8 = 1'b0; cyc();
    cfg8.cfg_valid = 1'b1; cfg8.cfg_step = s; cyc();
    cfg8.cfg_valid = 1'b0; clr8 = 1'b1; cyc();
    clr8 = 1'b0; en8 = 1'b1; cyc();
  endtask

  initial begin
    logic [7:0]  exp_t2;
    logic [10:0] exp_t3;
    int          ticks;
    real         ppm;
    exp_t2 = 8'b1010_0100;
    exp_t3 = 11'b011_1010_1000;
    cfg8.cfg_valid = 1'b0; cfg8.cfg_step = '0;
    cfg32.cfg_valid = 1'b0; cfg32.cfg_step = '0;

    chk("pkg_step32", step_from_rate(1.0e6, 100.0e6, 32), 64'd42949673);
    chk("pkg_step8", step_from_rate(1.0e6, 100.0e6, 8), 64'd3);
    chk("pkg_step96", step_from_rate(0.375, 1.0, 8), 64'd96);
    ppm = rate_error_ppm(1.0e6, 100.0e6, 32);
    chk("pkg_ppm_range", 64'(ppm > 0.0 && ppm < 0.001), 64'd1);

    // Reset state, then step 64: tick every 4th RUN edge.
    cyc(); cyc();
    chk("rst_tick", 64'(tick8), 0);
    chk("rst_cnt", 64'(cnt8), 0);
    chk("rst_running", 64'(run8), 0);
    chk("rst_pending", 64'(pend8), 0);
    chk("rst_ready", 64'(cfg8.cfg_ready), 1);
    rst8 = 1'b0; cyc();
    chk("t1_running", 64'(run8), 1);
    chk("t1_tick_e0", 64'(tick8), 0);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      chk("t1_tick", 64'(tick8), 64'(k % 4 == 0));
    end
    chk("t1_cnt32", 64'(cnt8), 8);

    // Step 96: periods 3,3,2 and the phase closes every 8 edges.
    en8 = 1'b0; cyc();
    chk("t2_idle_running", 64'(run8), 0);
    chk("t2_idle_tick", 64'(tick8), 0);
    cfg8.cfg_valid = 1'b1; cfg8.cfg_step = 8'd96; cyc();
    chk("t2_idle_load_pending", 64'(pend8), 0);
    cfg8.cfg_valid = 1'b0; clr8 = 1'b1; cyc();
    chk("t2_clr_cnt", 64'(cnt8), 0);
    clr8 = 1'b0; en8 = 1'b1; cyc();
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("t2_tick", 64'(tick8), 64'(exp_t2[(k - 1) % 8]));
    end
    chk("t2_cnt16", 64'(cnt8), 6);

    // Reload mid-period, second offer held while pending.
    restart8(8'd64);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      chk("t3_tick", 64'(tick8), 64'(exp_t3[k - 1]));
      if (k == 2) begin
        cfg8.cfg_valid = 1'b1; cfg8.cfg_step = 8'd128;
      end
      if (k == 3) begin
        chk("t3_pending_k3", 64'(pend8), 1);
        chk("t3_ready_k3", 64'(cfg8.cfg_ready), 0);
        cfg8.cfg_step = 8'd192;
      end
      if (k == 4) begin
        chk("t3_pending_k4", 64'(pend8), 0);
        chk("t3_ready_k4", 64'(cfg8.cfg_ready), 1);
      end
      if (k == 5) begin
        chk("t4_pending_k5", 64'(pend8), 1);
        chk("t4_ready_k5", 64'(cfg8.cfg_ready), 0);
        cfg8.cfg_valid = 1'b0;
      end
      if (k == 6) chk("t4_pending_k6", 64'(pend8), 0);
    end
    chk("t4_cnt", 64'(cnt8), 5);

    // Pause at acc=0x30 with step 16: resume keeps the phase.
    restart8(8'd16);
    cyc(); cyc(); cyc();
    en8 = 1'b0; cyc();
    chk("t5_pause_running", 64'(run8), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_pause_tick", 64'(tick8), 0);
      chk("t5_pause_running_hold", 64'(run8), 0);
    end
    en8 = 1'b1; cyc();
    for (int k = 1; k <= 13; k++) begin
      cyc();
      chk("t5_resume_tick", 64'(tick8), 64'(k == 13));
    end
    chk("t5_resume_cnt", 64'(cnt8), 1);
    for (int k = 14; k <= 28; k++) cyc();
    clr8 = 1'b1; cyc();
    chk("t5_clr_tick", 64'(tick8), 0);
    chk("t5_clr_cnt", 64'(cnt8), 0);
    clr8 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("t5_after_clr_tick", 64'(tick8), 64'(k == 16));
    end

    // Pending step applied on IDLE entry.
    cfg8.cfg_valid = 1'b1; cfg8.cfg_step = 8'd128; cyc();
    chk("t5_leave_pending_set", 64'(pend8), 1);
    cfg8.cfg_valid = 1'b0; en8 = 1'b0; cyc();
    chk("t5_leave_pending_clr", 64'(pend8), 0);
    en8 = 1'b1; cyc();
    cyc();
    chk("t5_newstep_k1", 64'(tick8), 0);
    cyc();
    chk("t5_newstep_k2", 64'(tick8), 1);

    // Default parameters: 1 MHz out of 100 MHz over 50000 RUN edges.
    rst32 = 1'b0; en32 = 1'b1; cyc();
    chk("t6_running", 64'(run32), 1);
    for (int k = 1; k <= 50000; k++) cyc();
    chk("t6_rate_window", 64'(cnt32 >= 32'd499 && cnt32 <= 32'd501), 1);
    cfg32.cfg_valid = 1'b1; cfg32.cfg_step = 32'h8000_0000; cyc();
    chk("t6_pending", 64'(pend32), 1);
    cfg32.cfg_valid = 1'b0; rst32 = 1'b1; cyc();
    chk("t6_rst_pending", 64'(pend32), 0);
    chk("t6_rst_ready", 64'(cfg32.cfg_ready), 1);
    chk("t6_rst_running", 64'(run32), 0);
    chk("t6_rst_cnt", 64'(cnt32), 0);
    rst32 = 1'b0; cyc();
    ticks = 0;
    for (int k = 1; k <= 100; k++) begin
      cyc();
      if (tick32) ticks++;
      if (k == 2)   chk("t6_defstep_k2", 64'(tick32), 0);
      if (k == 100) chk("t6_defstep_k100", 64'(tick32), 1);
    end
    chk("t6_defstep_ticks", 64'(ticks), 1);
    chk("t6_defstep_cnt", 64'(cnt32), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
